nes_pad_poller: RTL and testbench

//  Sequences the NES controller serial interface (latch/pulse/data) at a fixed poll rate.

---
 rtl/nes_pad_poller.sv | 124 ++++++++++++
 tb/tb_nes_pad_poller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_poller.sv
// NES controller poller: runs the latch/pulse/data handshake once per poll period
// and publishes the eight button bits as a registered, active-low vector.
module nes_pad_poller #(
   parameter int HALF_BIT    = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_pulse,
   output logic [7:0] buttons_n,
   output logic       frame_valid,
   output logic       changed
);

   localparam int PHASE_W = (2 * HALF_BIT > 1) ? $clog2(2 * HALF_BIT) : 1;
   localparam int POLL_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

   localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_BIT - 1);
   localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_BIT - 1);
   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, LATCH, READ, PULSE, DONE} PollState;

   PollState           state;
   PollState           nextState;
   logic [PHASE_W-1:0] phase;
   logic [POLL_W-1:0]  pollCount;
   logic [2:0]         bitIdx;
   logic [7:0]         shiftReg;
   logic               dataSync1;
   logic               dataSync2;
   logic               pollTick;
   logic               phaseDone;

   logic               latchNext;
   logic               pulseNext;
   logic [7:0]         shiftNext;
   logic [7:0]         buttonsNext;
   logic               frameValidNext;
   logic               changedNext;

   assign pollTick = (pollCount == POLL_LAST);

   always_comb begin
      phaseDone = 1'b1;
      unique case (state)
         LATCH:       phaseDone = (phase == LATCH_LAST);
         READ, PULSE: phaseDone = (phase == HALF_LAST);
         default:     phaseDone = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Ticks arriving outside IDLE are simply lost, so frames never back up.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (pollTick && enable) nextState = LATCH;
         LATCH:   if (phaseDone) nextState = READ;
         READ:    if (phaseDone) nextState = (bitIdx == 3'd7) ? DONE : PULSE;
         PULSE:   if (phaseDone) nextState = READ;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so the registered pins and
   // strobes line up exactly with the state they belong to.
   always_comb begin
      latchNext = (nextState == LATCH);
      pulseNext = (nextState == PULSE);
      shiftNext = shiftReg;
      if (state == READ && phaseDone) begin
         shiftNext[3'd7 - bitIdx] = dataSync2;
      end
      frameValidNext = (nextState == DONE);
      buttonsNext    = frameValidNext ? shiftNext : buttons_n;
      changedNext    = frameValidNext && (shiftNext != buttons_n);
   end

   // Datapath: poll counter, phase/bit counters, synchronizer and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pollCount   <= '0;
         phase       <= '0;
         bitIdx      <= 3'd0;
         shiftReg    <= 8'hFF;
         dataSync1   <= 1'b1;
         dataSync2   <= 1'b1;
         nes_latch   <= 1'b0;
         nes_pulse   <= 1'b0;
         buttons_n   <= 8'hFF;
         frame_valid <= 1'b0;
         changed     <= 1'b0;
      end else begin
         pollCount <= pollTick ? '0 : pollCount + 1'b1;
         phase     <= (nextState != state || state == IDLE) ? '0 : phase + 1'b1;
         if (nextState == LATCH && state != LATCH) begin
            bitIdx <= 3'd0;
         end else if (state == PULSE && phaseDone) begin
            bitIdx <= bitIdx + 3'd1;
         end
         dataSync1   <= nes_data;
         dataSync2   <= dataSync1;
         shiftReg    <= shiftNext;
         nes_latch   <= latchNext;
         nes_pulse   <= pulseNext;
         buttons_n   <= buttonsNext;
         frame_valid <= frameValidNext;
         changed     <= changedNext;
      end
   end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Self-checking bench for nes_pad_poller with HALF_BIT=4, POLL_PERIOD=100 and a
// shift-register model of the NES pad.
module tb_nes_pad_poller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_pulse;
   logic [7:0] buttons_n;
   logic       frame_valid;
   logic       changed;

   logic [7:0] padPattern = 8'hFF;
   logic [7:0] padShift = 8'hFF;
   logic       useOverride = 1'b0;
   logic       overrideVal = 1'b1;

   int checkCount = 0;
   int passCount = 0;
   int edgeCnt = 0;
   int latchRiseCount, latchHighCount, pulseRiseCount, pulseHighCount;
   int fvCount, changedCount, firstLatchEdge, firstFvEdge;
   int overlapCount = 0;
   logic prevLatch = 1'b0;
   logic prevPulse = 1'b0;

   typedef struct {
      logic [7:0] pattern;
      logic [7:0] expButtons;
      logic       expChanged;
   } FrameVec;

   FrameVec vecs[5];

   nes_pad_poller #(.HALF_BIT(4), .POLL_PERIOD(100)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .nes_data(nes_data),
      .nes_latch(nes_latch),
      .nes_pulse(nes_pulse),
      .buttons_n(buttons_n),
      .frame_valid(frame_valid),
      .changed(changed)
   );

   always #5 clk = ~clk;

   // Pad model: parallel load on latch, shift toward the data pin on each pulse.
   always @(posedge nes_latch or posedge nes_pulse) begin
      if (nes_latch) padShift = padPattern;
      else           padShift = {padShift[6:0], 1'b1};
   end

   assign nes_data = useOverride ? overrideVal : padShift[7];

   task automatic clearCounters();
      latchRiseCount = 0; latchHighCount = 0;
      pulseRiseCount = 0; pulseHighCount = 0;
      fvCount = 0; changedCount = 0;
      firstLatchEdge = -1; firstFvEdge = -1;
   endtask

   task automatic tick();
      @(posedge clk);
      edgeCnt++;
      @(negedge clk);
      if (nes_latch && !prevLatch) begin
         latchRiseCount++;
         if (firstLatchEdge < 0) firstLatchEdge = edgeCnt;
      end
      if (nes_pulse && !prevPulse) pulseRiseCount++;
      if (nes_latch) latchHighCount++;
      if (nes_pulse) pulseHighCount++;
      if (frame_valid) begin
         fvCount++;
         if (firstFvEdge < 0) firstFvEdge = edgeCnt;
      end
      if (changed) changedCount++;
      if (nes_latch && nes_pulse) overlapCount++;
      prevLatch = nes_latch;
      prevPulse = nes_pulse;
   endtask

   task automatic tickTo(input int target);
      while (edgeCnt < target) tick();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] pattern);
      padPattern = pattern;
   endtask

   task automatic waitFrameValid(input string name, input int limit);
      int n = 0;
      while (!frame_valid && n < limit) begin
         tick();
         n++;
      end
      if (!frame_valid) begin
         checkCount++;
         $display("[TB] FAIL %s: frame_valid not seen within %0d cycles, wanted 1", name, limit);
      end
   endtask

   task automatic findLatch(input int limitEdge, output int edgeAt);
      while (!nes_latch && edgeCnt < limitEdge) tick();
      edgeAt = nes_latch ? edgeCnt : -1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      edgeCnt = 0;
      clearCounters();
   endtask

   initial begin
      int latchAt;
      int n;

      vecs[0] = '{8'hFB, 8'hFB, 1'b1};
      vecs[1] = '{8'h7D, 8'h7D, 1'b1};
      vecs[2] = '{8'h7D, 8'h7D, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1};

      // Full first frame with an idle pad, checking reset values and timing.
      clearCounters();
      tick();
      tick();
      checkOutput("resetLatch", nes_latch, 0);
      checkOutput("resetPulse", nes_pulse, 0);
      checkOutput("resetButtons", buttons_n, 8'hFF);
      checkOutput("resetFrameValid", frame_valid, 0);
      checkOutput("resetChanged", changed, 0);
      reset = 1'b0;
      edgeCnt = 0;
      clearCounters();
      tickTo(170);
      checkOutput("firstLatchEdge", firstLatchEdge, 100);
      checkOutput("latchHighCycles", latchHighCount, 8);
      checkOutput("pulseHighCycles", pulseHighCount, 28);
      checkOutput("pulseRises", pulseRiseCount, 7);
      checkOutput("frameValidEdge", firstFvEdge, 168);
      checkOutput("frameValidCount", fvCount, 1);
      checkOutput("idleButtons", buttons_n, 8'hFF);
      checkOutput("idleChanged", changedCount, 0);

      // Directed frames from the table.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].pattern);
         tick();
         waitFrameValid($sformatf("vec%0dTimeout", i), 200);
         checkOutput($sformatf("vec%0dButtons", i), buttons_n, vecs[i].expButtons);
         checkOutput($sformatf("vec%0dChanged", i), changed, vecs[i].expChanged);
      end

      // enable dropped mid-frame: frame completes, then polling stops.
      clearCounters();
      n = 0;
      while (pulseRiseCount < 3 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("midFramePulseReached", pulseRiseCount, 3);
      enable = 1'b0;
      clearCounters();
      for (int i = 0; i < 300; i++) tick();
      checkOutput("disableFrameValid", fvCount, 1);
      checkOutput("disableNoLatch", latchRiseCount, 0);
      enable = 1'b1;

      // Reset in the middle of reading bit 5.
      applyStimulus(8'h7D);
      waitFrameValid("preResetTimeout", 200);
      tick();
      clearCounters();
      n = 0;
      while (!(pulseRiseCount == 5 && !nes_pulse) && n < 200) begin
         tick();
         n++;
      end
      checkOutput("preResetButtons", buttons_n, 8'h7D);
      reset = 1'b1;
      tick();
      checkOutput("abortLatch", nes_latch, 0);
      checkOutput("abortPulse", nes_pulse, 0);
      checkOutput("abortButtons", buttons_n, 8'hFF);
      checkOutput("abortFrameValid", frame_valid, 0);
      reset = 1'b0;
      edgeCnt = 0;
      clearCounters();
      findLatch(150, latchAt);
      checkOutput("postResetLatchEdge", latchAt, 100);

      // Disabled from reset: no pad activity, then polling resumes on the next tick.
      enable = 1'b0;
      applyReset();
      tickTo(500);
      checkOutput("disabledLatchCycles", latchHighCount, 0);
      checkOutput("disabledPulseCycles", pulseHighCount, 0);
      checkOutput("disabledFrameValid", fvCount, 0);
      checkOutput("disabledButtons", buttons_n, 8'hFF);
      tickTo(510);
      enable = 1'b1;
      findLatch(650, latchAt);
      checkOutput("resumeLatchEdge", latchAt, 600);

      // Synchronizer latency: bit 7 is sampled at edge 112 from data seen at edge 110.
      useOverride = 1'b1;
      overrideVal = 1'b1;
      applyReset();
      tickTo(110);
      overrideVal = 1'b0;
      tickTo(168);
      checkOutput("syncFrameAValid", frame_valid, 1);
      checkOutput("syncFrameAButtons", buttons_n, 8'h80);
      tickTo(209);
      overrideVal = 1'b1;
      tickTo(268);
      checkOutput("syncFrameBButtons", buttons_n, 8'hFF);
      checkOutput("syncFrameBChanged", changed, 1);
      useOverride = 1'b0;

      checkOutput("latchPulseOverlap", overlapCount, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
